// File: rtl/sw_debouncer.sv
// sw_debouncer: synchronises a raw, bouncing switch level to clk and qualifies
// every candidate transition over STABLE_CYCLES consecutive sampled edges
// before changing the clean level. It also emits registered single-cycle
// rise/fall pulses and a busy flag while a transition is being qualified.
module sw_debouncer #(
  parameter int STABLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic clk,
  input  logic reset,     // asynchronous, active-low
  input  logic in_sw,
  output logic out_d,
  output logic out_rise,
  output logic out_fall,
  output logic out_busy
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  // Out-of-range parameters are rejected at elaboration.
  if (STABLE_CYCLES < 1) begin : g_chk_stable
    $error("sw_debouncer: STABLE_CYCLES must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("sw_debouncer: SYNC_STAGES must be >= 2");
  end

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'b00,
    WAIT_HIGH = 2'b01,
    IDLE_HIGH = 2'b11,
    WAIT_LOW  = 2'b10
  } state_t;

  logic [SYNC_STAGES-1:0] sync_d, sync_q;
  logic                   s;
  state_t                 state_d, state_q;
  logic [CW-1:0]          cnt_d, cnt_q;
  logic                   lvl_d, lvl_q;
  logic                   rise_d, rise_q;
  logic                   fall_d, fall_q;
  logic                   busy_d, busy_q;

  // Shift the raw level into the synchroniser chain; only the last stage is used.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], in_sw};
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Synchroniser register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  // Next-state, counter and registered-output logic for the qualifying FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      IDLE_LOW: begin
        if (s) begin
          if (STABLE_CYCLES == 1) begin
            state_d = IDLE_HIGH;
            cnt_d   = '0;
            rise_d  = 1'b1;
          end else begin
            state_d = WAIT_HIGH;
            cnt_d   = CW'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          // Bounce back: abandon the candidate and restart the count later.
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      IDLE_HIGH: begin
        if (!s) begin
          if (STABLE_CYCLES == 1) begin
            state_d = IDLE_LOW;
            cnt_d   = '0;
            fall_d  = 1'b1;
          end else begin
            state_d = WAIT_LOW;
            cnt_d   = CW'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
      end
    endcase
    // Outputs are decoded from the next state so they can be registered.
    lvl_d  = (state_d == IDLE_HIGH) || (state_d == WAIT_LOW);
    busy_d = (state_d == WAIT_HIGH) || (state_d == WAIT_LOW);
  end

  // FSM state, counter and output registers; reset aborts any qualification.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      lvl_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign out_d    = lvl_q;
  assign out_rise = rise_q;
  assign out_fall = fall_q;
  assign out_busy = busy_q;

endmodule

// File: tb/tb_sw_debouncer.sv
// Directed bench for sw_debouncer (STABLE_CYCLES=4, SYNC_STAGES=2, 100 ns clk).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Expected output vectors are {out_d, out_rise, out_fall, out_busy}.
module tb_sw_debouncer;

  logic clk = 1'b0;
  logic reset;
  logic in_sw;
  logic out_d, out_rise, out_fall, out_busy;

  // Downstream D latch with reset inactive and enable held high.
  logic latch_rst_n = 1'b1;
  logic latch_en    = 1'b1;
  logic latch_q;
  logic latch_qb;

  int n_cmp = 0;
  int n_bad = 0;

  sw_debouncer #(.STABLE_CYCLES(4), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_sw    (in_sw),
    .out_d    (out_d),
    .out_rise (out_rise),
    .out_fall (out_fall),
    .out_busy (out_busy)
  );

  always #50 clk = ~clk;

  always_latch begin
    if (!latch_rst_n)  latch_q <= 1'b0;
    else if (latch_en) latch_q <= out_d;
  end
  assign latch_qb = ~latch_q;

  task automatic chk(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {out_d, out_rise, out_fall, out_busy};
    n_cmp++;
    assert (obs === exp)
      else begin
        n_bad++;
        $error("FAIL %s: outputs observed=%b expected=%b", tag, obs, exp);
      end
  endtask

  task automatic chk_latch(input string tag, input logic exp_d);
    n_cmp++;
    assert ({latch_q, latch_qb} === {exp_d, ~exp_d})
      else begin
        n_bad++;
        $error("FAIL %s: latch q/qb observed=%b%b expected=%b%b",
               tag, latch_q, latch_qb, exp_d, ~exp_d);
      end
  endtask

  // Runs n edges; step i drives ins[n-1-i] before the edge and then checks
  // nibble exps[4*(n-1-i) +: 4] (both read left to right in the literals).
  task automatic run_seq(input string tag, input int n,
                         input logic [15:0] ins, input logic [63:0] exps);
    logic [3:0] e;
    for (int i = 0; i < n; i++) begin
      in_sw = ins[n-1-i];
      @(posedge clk);
      @(negedge clk);
      e = exps[4*(n-1-i) +: 4];
      chk($sformatf("%s_e%0d", tag, i + 1), e);
      if (tag == "rst_rise" || tag == "clean_fall")
        chk_latch($sformatf("%s_latch_e%0d", tag, i + 1), e[3]);
    end
  endtask

  initial begin
    // Hold reset for 300 ns with the switch already high.
    reset = 1'b0;
    in_sw = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("in_reset_%0d", i), 4'b0000);
    end

    // Release: out_d rises on the 6th edge with a single rise pulse.
    reset = 1'b1;
    run_seq("rst_rise", 7, 16'b1111111, 64'h00111C8);

    // Clean step down: fall pulse on the 6th edge.
    run_seq("clean_fall", 7, 16'b0000000, 64'h8899920);

    // Bounce rejection: high 2, low 1, high 2, then low.
    run_seq("bounce", 9, 16'b110110000, 64'h001101100);

    // Bounce on the edge that would complete the count, then a stable high.
    run_seq("last_edge", 11, 16'b11101111111, 64'h001110111C8);

    // Back to low before the reset-abort scenario.
    run_seq("fall2", 7, 16'b0000000, 64'h8899920);

    // Start qualifying a rise, then abort it with reset between edges.
    run_seq("pre_abort", 3, 16'b111, 64'h001);
    #20;
    reset = 1'b0;
    #1;
    chk("abort_immediate", 4'b0000);
    @(posedge clk);
    @(negedge clk);
    chk("abort_held", 4'b0000);
    @(negedge clk);
    reset = 1'b1;
    run_seq("rerelease", 7, 16'b1111111, 64'h00111C8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
